// File: rtl/uart_pkg.sv
// Shared UART definitions: TX FSM encoding,
// baud-select codes and line constants.
package uart_pkg;

    localparam logic [2:0] ENC_IDLE   = 3'd0;
    localparam logic [2:0] ENC_WAIT   = 3'd1;
    localparam logic [2:0] ENC_START  = 3'd2;
    localparam logic [2:0] ENC_DATA   = 3'd3;
    localparam logic [2:0] ENC_PARITY = 3'd4;
    localparam logic [2:0] ENC_STOP   = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE   = ENC_IDLE,
        S_WAIT   = ENC_WAIT,
        S_START  = ENC_START,
        S_DATA   = ENC_DATA,
        S_PARITY = ENC_PARITY,
        S_STOP   = ENC_STOP
    } tx_state_e;

    // Baud-select codes understood by baud_gen
    localparam logic [1:0] BAUD_SEL_0 = 2'b00;
    localparam logic [1:0] BAUD_SEL_1 = 2'b01;
    localparam logic [1:0] BAUD_SEL_2 = 2'b10;
    localparam logic [1:0] BAUD_SEL_3 = 2'b11;

    localparam logic IDLE_LINE = 1'b1;

endpackage

// File: rtl/uart_tx_if.sv
// Host-side byte interface of the UART
// transmitter: request, config and status.
interface uart_tx_if #(
    parameter int DATA_BITS = 8
) ();

    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_start;
    logic                 parity_en;
    logic                 parity_odd;
    logic                 two_stop;
    logic                 busy;
    logic                 done;

    modport master (
        output tx_data, tx_start,
        output parity_en, parity_odd, two_stop,
        input  busy, done
    );

    modport slave (
        input  tx_data, tx_start,
        input  parity_en, parity_odd, two_stop,
        output busy, done
    );

endinterface

// File: rtl/uart_tx_baud_tick_detect.sv
// Turns the baud square wave into a one-clock
// tick on each rising edge (shared with uart_rx).
module baud_tick_detect (
    input  logic clock,
    input  logic rst,
    input  logic baud_clk,
    output logic tick
);

    logic baud_clk_q;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) baud_clk_q <= 1'b0;
        else      baud_clk_q <= baud_clk;
    end

    assign tick = baud_clk & ~baud_clk_q;

endmodule

// File: rtl/uart_tx.sv
// UART frame serializer: start, LSB-first data,
// optional parity, one or two stop bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       baud_clk,
    uart_tx_if.slave   bus,
    output logic       tx
);

    localparam int CW = $clog2(DATA_BITS) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

    tx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 par_q, par_d;
    logic                 pe_q, pe_d;
    logic                 ts_q, ts_d;
    logic                 tick;
    logic                 done;

    baud_tick_detect u_tick (
        .clock    (clock),
        .rst      (rst),
        .baud_clk (baud_clk),
        .tick     (tick)
    );

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            pe_q    <= 1'b0;
            ts_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            pe_q    <= pe_d;
            ts_q    <= ts_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        pe_d    = pe_q;
        ts_d    = ts_q;
        done    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // A tick in the acceptance cycle is ignored: WAIT
                // only starts looking at ticks from the next clock.
                if (bus.tx_start) begin
                    shift_d = bus.tx_data;
                    pe_d    = bus.parity_en;
                    ts_d    = bus.two_stop;
                    par_d   = ^bus.tx_data ^ bus.parity_odd;
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (tick) state_d = S_START;
            end
            S_START: begin
                if (tick) begin
                    cnt_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (cnt_q == LAST_BIT) begin
                        cnt_d   = '0;
                        state_d = pe_q ? S_PARITY : S_STOP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    cnt_d   = '0;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                // The counter is reused to count stop bits.
                if (tick) begin
                    if (cnt_q == {{(CW-1){1'b0}}, ts_q}) begin
                        done    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tx = IDLE_LINE;
        unique case (state_q)
            S_START:  tx = 1'b0;
            S_DATA:   tx = shift_q[0];
            S_PARITY: tx = par_q;
            default:  tx = IDLE_LINE;
        endcase
    end

    assign bus.done = done;
    assign bus.busy = (state_q != S_IDLE) && !done;

endmodule

// File: tb/tb_uart_tx.sv
// Randomized self-checking bench for uart_tx
// against a frame-level reference model.
module tb_uart_tx;

    localparam int DB = 8;

    logic clock = 1'b0;
    logic rst = 1'b0;
    logic baud_clk = 1'b0;
    logic tx;
    int   ph = 7;
    int   checks = 0;
    int   errors = 0;

    uart_tx_if #(.DATA_BITS(DB)) bus ();

    uart_tx #(.DATA_BITS(DB)) dut (
        .clock    (clock),
        .rst      (rst),
        .baud_clk (baud_clk),
        .bus      (bus),
        .tx       (tx)
    );

    always #5 clock = ~clock;

    // 8-clock baud period, 4 high / 4 low; ph==0 marks the rising edge
    always @(negedge clock) begin
        ph = (ph + 1) % 8;
        baud_clk = (ph < 4);
    end

    initial begin
        #1ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic idle_watch(input string tag, input int n);
        int lows = 0;
        for (int i = 0; i < n; i++) begin
            if (tx !== 1'b1 || bus.busy !== 1'b0) lows++;
            step();
        end
        chk(tag, lows, 0);
    endtask

    // mode: 0 plain, 1 mid-frame re-request, 2 hold start, 3 reset mid-frame
    task automatic send(input logic [7:0] d, input logic pe,
                        input logic po, input logic ts,
                        input int mode, output int got_wait);
        logic   q[$];
        logic [7:0] wv, bv, dv;
        int     w, expw, n;
        q.push_back(1'b0);
        for (int i = 0; i < DB; i++) q.push_back(d[i]);
        if (pe) q.push_back((^d) ^ po);
        q.push_back(1'b1);
        if (ts) q.push_back(1'b1);
        n = q.size();

        bus.tx_data    = d;
        bus.parity_en  = pe;
        bus.parity_odd = po;
        bus.two_stop   = ts;
        bus.tx_start   = 1'b1;
        step();
        if (mode != 2) begin
            bus.tx_start   = 1'b0;
            bus.tx_data    = ~d;
            bus.parity_en  = ~pe;
            bus.parity_odd = ~po;
            bus.two_stop   = ~ts;
        end
        chk("busy_acc", bus.busy, 1);
        expw = ((8 - ph) % 8) + 1;
        w = 0;
        while (tx !== 1'b0 && w < 40) begin
            step();
            w++;
        end
        got_wait = w;
        chk("wait_len", w, expw);
        if (tx !== 1'b0) return;

        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < 8; j++) begin
                wv[j] = tx;
                bv[j] = bus.busy;
                dv[j] = bus.done;
                if (mode == 1) begin
                    bus.tx_start = (k == 4 && j == 2);
                    if (k == 4 && j == 2) bus.tx_data = 8'h00;
                end
                if (mode == 3 && k == 5 && j == 3) begin
                    rst = 1'b0;
                    #1;
                    chk("rst_tx", tx, 1);
                    chk("rst_busy", bus.busy, 0);
                    chk("rst_done", bus.done, 0);
                    step();
                    step();
                    rst = 1'b1;
                    idle_watch("post_rst_idle", 24);
                    return;
                end
                step();
            end
            chk($sformatf("bit%0d", k), wv, {8{q[k]}});
            chk($sformatf("busy%0d", k), bv, (k == n - 1) ? 8'h7F : 8'hFF);
            chk($sformatf("done%0d", k), dv, (k == n - 1) ? 8'h80 : 8'h00);
        end
        chk("end_tx", tx, 1);
        chk("end_busy", bus.busy, 0);
        if (mode == 1) idle_watch("no_second", 24);
    endtask

    initial begin
        int gw;
        bus.tx_data    = '0;
        bus.tx_start   = 1'b0;
        bus.parity_en  = 1'b0;
        bus.parity_odd = 1'b0;
        bus.two_stop   = 1'b0;
        rst = 1'b0;
        step();
        step();
        chk("reset_tx", tx, 1);
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        rst = 1'b1;
        repeat (5) step();

        send(8'h55, 1'b0, 1'b0, 1'b0, 0, gw);
        repeat (3) step();
        send(8'h07, 1'b1, 1'b0, 1'b0, 0, gw);
        repeat (5) step();
        send(8'h07, 1'b1, 1'b1, 1'b0, 0, gw);
        repeat (2) step();
        send(8'hFF, 1'b0, 1'b0, 1'b1, 0, gw);
        repeat (7) step();
        send(8'hA5, 1'b0, 1'b0, 1'b0, 1, gw);

        send(8'h3C, 1'b0, 1'b0, 1'b0, 2, gw);
        send(8'hC5, 1'b1, 1'b0, 1'b0, 2, gw);
        chk("gap1", gw, 7);
        send(8'h5A, 1'b0, 1'b0, 1'b1, 2, gw);
        chk("gap2", gw, 7);
        bus.tx_start = 1'b0;
        idle_watch("hold_release", 16);

        send(8'hC3, 1'b1, 1'b1, 1'b0, 3, gw);

        for (int i = 0; i < 10 && ph != 0; i++) step();
        chk("align_phase", ph, 0);
        send(8'h96, 1'b0, 1'b0, 1'b0, 0, gw);
        chk("coincident", gw, 8);

        for (int i = 0; i < 30; i++) begin
            send(8'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 0, gw);
            repeat ($urandom_range(0, 20)) step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
